pulse_timestamp_fifo: RTL

- Consumes the one-cycle edge pulses from the falling-edge pulse generator (e.g. trigger or gate-end pulses), already synchronous to `clock`.
- Stamps each pulse with a free-running cycle counter and a pulse sequence number.
- Buffers the stamps in a small FIFO for the LV2 readout logic, which drains it with a valid/ready handshake.
- Counts and flags pulses lost to FIFO overflow.

---
 rtl/pulse_ts_defs.sv | 13 +
 rtl/ts_fifo_sync.sv | 72 +++++++
 rtl/pulse_timestamp_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/pulse_ts_defs.sv
// rtl/pulse_ts_defs.sv - shared widths and entry layout for the pulse timestamp FIFO
package pulse_ts_defs;

    localparam int TS_W_DEF       = 32;
    localparam int SEQ_W_DEF      = 16;
    localparam int DEPTH_LOG2_DEF = 4;
    localparam int DROP_W_DEF     = 16;
    localparam int DEADTIME_DEF   = 8;

    // FIFO entry is {timestamp, sequence}, timestamp in the upper bits
    localparam int ENTRY_W = TS_W_DEF + SEQ_W_DEF;

endpackage

// File: rtl/ts_fifo_sync.sv
// rtl/ts_fifo_sync.sv - single-clock first-word-fall-through FIFO
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   push, push_data     write request and data (ignored when full without pop)
//   pop                 read request (ignored when empty)
//   pop_data            registered head entry; holds last value while empty
//   full, empty, level  occupancy status, level is 0..2**AW
module ts_fifo_sync #(
    parameter int W  = 48,
    parameter int AW = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(2**AW));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // Head register: the incoming word becomes the head when the queue
            // is (or is about to be) otherwise empty; else the next stored word
            if (do_push && (empty || (do_pop && count == (AW+1)'(1)))) begin
                pop_data <= push_data;
            end else if (do_pop && count > (AW+1)'(1)) begin
                pop_data <= mem[rd_ptr + AW'(1)];
            end
        end
    end

endmodule

// File: rtl/pulse_timestamp_fifo.sv
// rtl/pulse_timestamp_fifo.sv - timestamps edge pulses and queues them for readout
//
// Ports:
//   clock, reset_n           system clock, asynchronous active-low reset
//   pulse                    one-cycle pulse from the edge detector
//   ts_clear                 zero the timestamp counter on the next cycle
//   out_valid/out_ready      head-entry handshake toward the readout
//   out_timestamp, out_seq   head entry contents
//   fifo_level               registered occupancy
//   drop_count, overflow     saturating drop counter and sticky overflow flag
//
// Optional: define PULSE_DEADTIME_EN to ignore pulses for DEADTIME cycles after
// each accepted pulse.
module pulse_timestamp_fifo
    import pulse_ts_defs::*;
#(
    parameter int TS_W       = TS_W_DEF,
    parameter int SEQ_W      = SEQ_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int DROP_W     = DROP_W_DEF,
    parameter int DEADTIME   = DEADTIME_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pulse,
    input  logic                  ts_clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TS_W-1:0]       out_timestamp,
    output logic [SEQ_W-1:0]      out_seq,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [DROP_W-1:0]     drop_count,
    output logic                  overflow
);

    localparam int ENTRY_BITS = TS_W + SEQ_W;

    logic [TS_W-1:0]       ts_cnt;
    logic [SEQ_W-1:0]      seq_cnt;
    logic                  qualified;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop_evt;
    logic [ENTRY_BITS-1:0] head;

`ifdef PULSE_DEADTIME_EN
    localparam int DT_W = ($clog2(DEADTIME + 1) > 8) ? $clog2(DEADTIME + 1) : 8;

    logic [DT_W-1:0] dt_cnt;

    assign qualified = pulse && (dt_cnt == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dt_cnt <= '0;
        end else if (qualified) begin
            dt_cnt <= DT_W'(DEADTIME);
        end else if (dt_cnt != '0) begin
            dt_cnt <= dt_cnt - DT_W'(1);
        end
    end
`else
    logic unused_deadtime;

    assign unused_deadtime = (DEADTIME != 0);
    assign qualified       = pulse;
`endif

    // out_valid implies the pop; a full FIFO is never empty, so out_ready alone
    // tells whether the head leaves this cycle
    assign drop_evt = qualified && fifo_full && !out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt     <= '0;
            seq_cnt    <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            ts_cnt <= ts_clear ? '0 : ts_cnt + TS_W'(1);
            // Dropped pulses still consume a sequence number so gaps are visible
            if (qualified) begin
                seq_cnt <= seq_cnt + SEQ_W'(1);
            end
            if (drop_evt) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end
        end
    end

    ts_fifo_sync #(
        .W  (ENTRY_BITS),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (qualified),
        .push_data ({ts_cnt, seq_cnt}),
        .pop       (out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_valid     = !fifo_empty;
    assign out_timestamp = head[ENTRY_BITS-1:SEQ_W];
    assign out_seq       = head[SEQ_W-1:0];

endmodule
